wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameters SHALL be: dw, default 32, Wishbone data width; APP_AW, default 26, application address width; TO_CYC, default 255, ack timeout in cycles (1..65535).
REQ-002 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous assert, active-high; deassertion synchronous to sys_clk.
REQ-004 sdr_init_done  in  1  SDRAM controller initialisation complete.
REQ-005 req_valid  in  1 / req_ready  out  1  command handshake; a command is accepted when both are high on a sys_clk edge.
REQ-006 req_we  in  1  write=1, read=0 / req_addr  in  APP_AW  start byte address / req_sel  in  dw/8  byte enables for all beats / req_len  in  4  beat count, 1..15; 0 is treated as 1.
REQ-007 wd_valid  in  1 / wd_data  in  dw / wd_ready  out  1  write-data stream, one word per beat.
REQ-008 rd_valid  out  1 / rd_data  out  dw  read-data stream, no backpressure.
REQ-009 done  out  1  one-cycle end-of-command pulse / err  out  1  valid with done, 1 = timeout abort.
REQ-010 wb_cyc_i, wb_stb_i, wb_we_i  out  1 each / wb_addr_i  out  APP_AW / wb_dat_i  out  dw / wb_sel_i  out  dw/8 / wb_cti_i  out  3: Wishbone master outputs to the SDRAM controller.
REQ-011 wb_ack_o  in  1 / wb_dat_o  in  dw: Wishbone slave responses.

Function
REQ-012 FSM states SHALL be INIT, IDLE, BUS, END; INIT is entered on reset.
REQ-013 INIT -> IDLE on the first edge with sdr_init_done=1; req_ready SHALL be 0 in INIT.
REQ-014 req_ready SHALL be 1 only in IDLE with sdr_init_done=1; IDLE returns to INIT if sdr_init_done falls; a fall in BUS or END is ignored until the command ends.
REQ-015 On acceptance the block SHALL register we, addr, sel and len, clear the beat and timeout counters, and enter BUS next cycle with wb_cyc_i=1.
REQ-016 In BUS, wb_stb_i SHALL equal 1 for reads and wd_valid for writes; wb_cyc_i stays 1 throughout BUS.
REQ-017 wb_dat_i SHALL equal wd_data; wd_ready SHALL equal wb_ack_o AND wb_stb_i AND wb_we_i AND (state=BUS).
REQ-018 A beat completes on any edge in BUS with wb_ack_o=1 and wb_stb_i=1; ack while wb_stb_i=0 SHALL be ignored.
REQ-019 On each read beat, rd_valid SHALL pulse 1 cycle later with rd_data = registered wb_dat_o.
REQ-020 wb_addr_i SHALL start at req_addr and advance by dw/8 per completed beat, modulo 2^APP_AW (wrap to 0 allowed).
REQ-021 wb_cti_i SHALL be 3'b010 while beats remain and 3'b111 on the final beat; single-beat commands use 3'b111.
REQ-022 After the final beat completes: BUS -> END; in END cyc/stb are 0, done=1 and err=0 for one cycle, then IDLE.
REQ-023 The timeout counter SHALL increment each BUS cycle without a completed beat and clear on each beat; at TO_CYC it SHALL drop cyc/stb and enter END with done=1, err=1.
REQ-024 After a timeout, unconsumed write words SHALL NOT be accepted by this block; the requester discards them.
REQ-025 wb_we_i and wb_sel_i SHALL hold the registered command values during BUS and be 0 outside BUS.
REQ-026 A new command SHALL NOT be accepted in the END cycle; back-to-back commands have one idle bus cycle minimum.

Reset
REQ-027 Asserting wb_rst_i SHALL immediately force wb_cyc_i=0, wb_stb_i=0, wb_we_i=0, wb_addr_i=0, wb_sel_i=0, wb_cti_i=0, req_ready=0, wd_ready=0, rd_valid=0, rd_data=0, done=0, err=0, all counters 0, state INIT, including mid-burst.
REQ-028 After reset release the block SHALL wait for sdr_init_done again before accepting commands.

Verification
REQ-029 sdr_init_done=0 for 100 cycles with req_valid=1 -> req_ready=0, wb_cyc_i=0 throughout; raise it -> req_ready=1 the next cycle.
REQ-030 Write len=4, addr=0x100, sel=4'hF, data A..D, slave acks each cycle -> wb_addr_i 0x100/0x104/0x108/0x10C, cti 010,010,010,111, four wd_ready pulses, done=1 err=0.
REQ-031 Read len=1 at addr=0x3FFFFFC, ack after 3 waits returning 0xDEADBEEF -> cti=111, rd_valid one cycle after ack with 0xDEADBEEF, done=1.
REQ-032 Read len=2 at addr=0x3FFFFFC -> second beat at addr 0x0000000.
REQ-033 TO_CYC=8, slave never acks -> cyc/stb drop after 8 BUS cycles, done=1 err=1, then IDLE with req_ready=1.
REQ-034 wb_rst_i asserted during beat 2 of a 4-beat write -> cyc/stb/done 0 same cycle; no done pulse; state INIT after release.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Wishbone burst master: turns queued application commands into
// incrementing Wishbone bursts toward the SDRAM controller.
module wb_cmd_master #(
  parameter int dw     = 32,
  parameter int APP_AW = 26,
  parameter int TO_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [dw/8-1:0]   req_sel,
  input  logic [3:0]        req_len,
  input  logic              wd_valid,
  input  logic [dw-1:0]     wd_data,
  output logic              wd_ready,
  output logic              rd_valid,
  output logic [dw-1:0]     rd_data,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_i,
  output logic              wb_stb_i,
  output logic              wb_we_i,
  output logic [APP_AW-1:0] wb_addr_i,
  output logic [dw-1:0]     wb_dat_i,
  output logic [dw/8-1:0]   wb_sel_i,
  output logic [2:0]        wb_cti_i,
  input  logic              wb_ack_o,
  input  logic [dw-1:0]     wb_dat_o
);

  localparam logic [15:0]       TO_LAST = 16'(TO_CYC - 1);
  localparam logic [APP_AW-1:0] STEP    = APP_AW'(dw / 8);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    BUS,
    END
  } state_e;

  state_e              state_q;
  logic                we_q;
  logic [APP_AW-1:0]   addr_q;
  logic [dw/8-1:0]     sel_q;
  logic [3:0]          len_q;
  logic [3:0]          beat_q;
  logic [15:0]         to_q;
  logic                rd_valid_q;
  logic [dw-1:0]       rd_data_q;
  logic                done_q;
  logic                err_q;

  logic in_bus;
  logic beat;
  logic last;

  assign in_bus   = (state_q == BUS);
  assign wb_cyc_i = in_bus;
  assign wb_stb_i = in_bus & (we_q ? wd_valid : 1'b1);
  assign wb_we_i  = in_bus & we_q;
  assign wb_sel_i = in_bus ? sel_q : '0;
  assign wb_addr_i = addr_q;
  assign wb_dat_i = wd_data;
  assign beat     = wb_stb_i & wb_ack_o;
  assign last     = (beat_q == len_q - 4'd1);
  assign wb_cti_i = in_bus ? (last ? 3'b111 : 3'b010) : 3'b000;
  assign wd_ready = beat & we_q;
  assign req_ready = (state_q == IDLE) & sdr_init_done;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign err      = err_q;

  always_ff @(posedge sys_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= INIT;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      len_q      <= 4'd1;
      beat_q     <= '0;
      to_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (sdr_init_done) state_q <= IDLE;
        end
        IDLE: begin
          if (!sdr_init_done) begin
            state_q <= INIT;
          end else if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            sel_q   <= req_sel;
            len_q   <= (req_len == 4'd0) ? 4'd1 : req_len;
            beat_q  <= '0;
            to_q    <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (beat) begin
            to_q   <= '0;
            addr_q <= addr_q + STEP;
            if (!we_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= wb_dat_o;
            end
            if (last) begin
              state_q <= END;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end else if (to_q == TO_LAST) begin
            // Slave stopped answering: abandon the rest of the burst.
            state_q <= END;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            to_q <= to_q + 16'd1;
          end
        end
        END: begin
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: command table plus init,
// timeout and mid-burst reset sequences.
module tb_wb_cmd_master;

  logic        sys_clk = 1'b0;
  logic        wb_rst_i;
  logic        sdr_init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [25:0] req_addr;
  logic [3:0]  req_sel;
  logic [3:0]  req_len;
  logic        wd_valid;
  logic [31:0] wd_data;
  logic        wd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [25:0] wb_addr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_cmd_master #(
    .dw(32),
    .APP_AW(26),
    .TO_CYC(8)
  ) dut (
    .sys_clk(sys_clk),
    .wb_rst_i(wb_rst_i),
    .sdr_init_done(sdr_init_done),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_sel(req_sel),
    .req_len(req_len),
    .wd_valid(wd_valid),
    .wd_data(wd_data),
    .wd_ready(wd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .done(done),
    .err(err),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_cti_i(wb_cti_i),
    .wb_ack_o(wb_ack_o),
    .wb_dat_o(wb_dat_o)
  );

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [3:0]  sel;
    logic [3:0]  len;
    int          waits;
    logic [31:0] dbase;
    int          exp_nb;
    logic [25:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Write waits are master stalls (wd_valid=0) with a stray ack;
  // read waits are slave wait states.
  task automatic run_cmd(input int id, input vec_t v);
    logic [25:0] a;
    logic        prev_rd;
    logic [31:0] prev_d;
    logic [31:0] d;
    logic        hit;
    a = v.addr;
    prev_rd = 1'b0;
    prev_d = '0;
    req_valid = 1'b1;
    req_we = v.we;
    req_addr = v.addr;
    req_sel = v.sel;
    req_len = v.len;
    #1 chk($sformatf("v%0d req_ready", id), req_ready, 1);
    cyc_step();
    req_valid = 1'b0;
    for (int b = 0; b < v.exp_nb; b++) begin
      for (int w = 0; w <= v.waits; w++) begin
        hit = (w == v.waits);
        d = v.dbase + 32'(b);
        wb_ack_o = hit | v.we;
        wd_valid = v.we & hit;
        wd_data = d;
        wb_dat_o = d;
        #1;
        chk($sformatf("v%0d b%0d cyc", id, b), wb_cyc_i, 1);
        chk($sformatf("v%0d b%0d addr", id, b), wb_addr_i, a);
        chk($sformatf("v%0d b%0d cti", id, b), wb_cti_i,
            (b == v.exp_nb - 1) ? 3'b111 : 3'b010);
        chk($sformatf("v%0d b%0d stb", id, b), wb_stb_i,
            v.we ? hit : 1'b1);
        chk($sformatf("v%0d b%0d we", id, b), wb_we_i, v.we);
        chk($sformatf("v%0d b%0d sel", id, b), wb_sel_i, v.sel);
        chk($sformatf("v%0d b%0d wd_ready", id, b), wd_ready,
            v.we & hit);
        chk($sformatf("v%0d b%0d rd_valid", id, b), rd_valid, prev_rd);
        if (prev_rd)
          chk($sformatf("v%0d b%0d rd_data", id, b), rd_data, prev_d);
        if (v.we)
          chk($sformatf("v%0d b%0d dat_i", id, b), wb_dat_i, d);
        if (hit && b == v.exp_nb - 1)
          chk($sformatf("v%0d last_addr", id), wb_addr_i, v.exp_last);
        prev_rd = ~v.we & hit;
        prev_d = d;
        cyc_step();
      end
      a = a + 26'd4;
    end
    wb_ack_o = 1'b0;
    wd_valid = 1'b0;
    req_valid = 1'b1;
    #1;
    chk($sformatf("v%0d end done", id), done, 1);
    chk($sformatf("v%0d end err", id), err, 0);
    chk($sformatf("v%0d end cyc", id), wb_cyc_i, 0);
    chk($sformatf("v%0d end stb", id), wb_stb_i, 0);
    chk($sformatf("v%0d end cti", id), wb_cti_i, 0);
    chk($sformatf("v%0d end we", id), wb_we_i, 0);
    chk($sformatf("v%0d end req_ready", id), req_ready, 0);
    chk($sformatf("v%0d end rd_valid", id), rd_valid, prev_rd);
    if (prev_rd)
      chk($sformatf("v%0d end rd_data", id), rd_data, prev_d);
    cyc_step();
    req_valid = 1'b0;
    #1;
    chk($sformatf("v%0d idle done", id), done, 0);
    chk($sformatf("v%0d idle cyc", id), wb_cyc_i, 0);
    chk($sformatf("v%0d idle req_ready", id), req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 26'h0000100, 4'hF, 4'd4, 0, 32'hA0, 4, 26'h000010C};
    tbl[1] = '{1'b0, 26'h3FFFFFC, 4'hF, 4'd1, 3, 32'hDEADBEEF, 1,
               26'h3FFFFFC};
    tbl[2] = '{1'b0, 26'h3FFFFFC, 4'hF, 4'd2, 0, 32'h11110000, 2,
               26'h0000000};
    tbl[3] = '{1'b1, 26'h0000200, 4'h3, 4'd0, 1, 32'h55AA0000, 1,
               26'h0000200};
    tbl[4] = '{1'b0, 26'h0000040, 4'hC, 4'd3, 2, 32'h12340000, 3,
               26'h0000048};

    wb_rst_i = 1'b1;
    sdr_init_done = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = '0;
    req_sel = '0;
    req_len = '0;
    wd_valid = 1'b0;
    wd_data = '0;
    wb_ack_o = 1'b0;
    wb_dat_o = '0;
    #1;
    chk("rst cyc", wb_cyc_i, 0);
    chk("rst stb", wb_stb_i, 0);
    chk("rst addr", wb_addr_i, 0);
    chk("rst cti", wb_cti_i, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst done", done, 0);
    @(negedge sys_clk);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 100; i++) begin
      #1;
      chk("init req_ready", req_ready, 0);
      chk("init cyc", wb_cyc_i, 0);
      @(negedge sys_clk);
    end
    sdr_init_done = 1'b1;
    req_valid = 1'b0;
    #1 chk("init rise same", req_ready, 0);
    @(negedge sys_clk);
    #1 chk("init rise next", req_ready, 1);
    sdr_init_done = 1'b0;
    #1 chk("idle fall", req_ready, 0);
    @(negedge sys_clk);
    sdr_init_done = 1'b1;
    #1 chk("back in init", req_ready, 0);
    @(negedge sys_clk);
    #1 chk("reinit ready", req_ready, 1);

    for (int i = 0; i < 5; i++) run_cmd(i, tbl[i]);

    // Slave never acks: abort after the timeout window.
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 26'h0000500;
    req_sel = 4'hF;
    req_len = 4'd2;
    wb_ack_o = 1'b0;
    #1 chk("to req_ready", req_ready, 1);
    cyc_step();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("to c%0d cyc", i), wb_cyc_i, 1);
      chk($sformatf("to c%0d stb", i), wb_stb_i, 1);
      chk($sformatf("to c%0d done", i), done, 0);
      cyc_step();
    end
    #1;
    chk("to cyc", wb_cyc_i, 0);
    chk("to stb", wb_stb_i, 0);
    chk("to done", done, 1);
    chk("to err", err, 1);
    cyc_step();
    #1;
    chk("to after done", done, 0);
    chk("to after err", err, 0);
    chk("to after ready", req_ready, 1);

    // Reset in the middle of beat 2 of a 4-beat write.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 26'h0000100;
    req_sel = 4'hF;
    req_len = 4'd4;
    #1 chk("rb req_ready", req_ready, 1);
    cyc_step();
    req_valid = 1'b0;
    wb_ack_o = 1'b1;
    wd_valid = 1'b1;
    wd_data = 32'hA;
    #1 chk("rb beat1 wd_ready", wd_ready, 1);
    cyc_step();
    wd_data = 32'hB;
    #1 chk("rb beat2 addr", wb_addr_i, 26'h104);
    #1 wb_rst_i = 1'b1;
    #1;
    chk("rb cyc", wb_cyc_i, 0);
    chk("rb stb", wb_stb_i, 0);
    chk("rb we", wb_we_i, 0);
    chk("rb addr", wb_addr_i, 0);
    chk("rb sel", wb_sel_i, 0);
    chk("rb cti", wb_cti_i, 0);
    chk("rb wd_ready", wd_ready, 0);
    chk("rb done", done, 0);
    chk("rb err", err, 0);
    chk("rb req_ready", req_ready, 0);
    cyc_step();
    wb_rst_i = 1'b0;
    wb_ack_o = 1'b0;
    wd_valid = 1'b0;
    #1;
    chk("rb rel ready", req_ready, 0);
    chk("rb rel done", done, 0);
    chk("rb rel cyc", wb_cyc_i, 0);
    @(negedge sys_clk);
    #1;
    chk("rb idle ready", req_ready, 1);
    chk("rb idle done", done, 0);
    chk("rb idle cyc", wb_cyc_i, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
